// File: rtl/sw_debounce_pkg.sv
// Shared defaults and sizing helper for the switch debouncer.
package sw_debounce_pkg;

    localparam int unsigned DEF_WIDTH         = 16;
    localparam int unsigned DEF_STABLE_CYCLES = 250000;

    // Stability counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter, accepted level and edge pulses.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned   CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          lvl_q, lvl_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            lvl_q  <= 1'b0;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= sw_i;
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Count consecutive disagreeing samples; accept once the run reaches STABLE_CYCLES.
    always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CNT_MAX) begin
                lvl_d  = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign q_o    = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH independent switch/button inputs into clean levels plus edge pulses.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .sw_i  (sw_in[i]),
            .q_o   (sw_out[i]),
            .rise_o(rise[i]),
            .fall_o(fall[i])
        );
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with STABLE_CYCLES=4 and STABLE_CYCLES=1 instances.
module tb_sw_debounce;

    logic        clk;
    logic        rst;
    logic [15:0] sw_in;
    logic [15:0] out4, rise4, fall4;
    logic [15:0] out1, rise1, fall1;

    int checks = 0;
    int errors = 0;

    sw_debounce #(.WIDTH(16), .STABLE_CYCLES(4)) u4 (
        .clk(clk), .rst(rst), .sw_in(sw_in),
        .sw_out(out4), .rise(rise4), .fall(fall4)
    );

    sw_debounce #(.WIDTH(16), .STABLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .sw_in(sw_in),
        .sw_out(out1), .rise(rise1), .fall(fall1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: raw samples per edge; a level is accepted once the synchronized
    // value (two samples back) has disagreed with it for S consecutive edges.
    logic [15:0] h[$];
    logic [15:0] mq4, mr4, mf4, mq1, mr1, mf1;

    function automatic logic [15:0] accept_mask(input int s, input logic [15:0] q);
        logic [15:0] a;
        logic [15:0] v;
        int n;
        n = h.size();
        for (int b = 0; b < 16; b++) begin
            a[b] = 1'b1;
            for (int j = 2; j <= s + 1; j++) begin
                v = h[n - 1 - j];
                if (v[b] == q[b]) a[b] = 1'b0;
            end
        end
        return a;
    endfunction

    task automatic model_clear();
        h.delete();
        repeat (6) h.push_back(16'h0000);
        mq4 = '0; mr4 = '0; mf4 = '0;
        mq1 = '0; mr1 = '0; mf1 = '0;
    endtask

    task automatic model_edge();
        logic [15:0] a4, a1;
        h.push_back(sw_in);
        a4  = accept_mask(4, mq4);
        a1  = accept_mask(1, mq1);
        mr4 = a4 & ~mq4;
        mf4 = a4 & mq4;
        mq4 = mq4 ^ a4;
        mr1 = a1 & ~mq1;
        mf1 = a1 & mq1;
        mq1 = mq1 ^ a1;
        while (h.size() > 6) void'(h.pop_front());
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " out4"},  out4,  mq4);
        chk({tag, " rise4"}, rise4, mr4);
        chk({tag, " fall4"}, fall4, mf4);
        chk({tag, " out1"},  out1,  mq1);
        chk({tag, " rise1"}, rise1, mr1);
        chk({tag, " fall1"}, fall1, mf1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Pulse reset between edges and confirm every output clears without a clock.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, " rst out4"},  out4,  16'h0000);
        chk({tag, " rst rise4"}, rise4, 16'h0000);
        chk({tag, " rst fall4"}, fall4, 16'h0000);
        chk({tag, " rst out1"},  out1,  16'h0000);
        chk({tag, " rst rise1"}, rise1, 16'h0000);
        chk({tag, " rst fall1"}, fall1, 16'h0000);
        model_clear();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] sw;
        logic [15:0] o4, r4, f4;
        logic [15:0] o1, r1, f1;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic [15:0] sw,
                                input logic [15:0] o4, input logic [15:0] r4, input logic [15:0] f4,
                                input logic [15:0] o1, input logic [15:0] r1, input logic [15:0] f1);
        vec_t v;
        v.sw = sw; v.o4 = o4; v.r4 = r4; v.f4 = f4;
        v.o1 = o1; v.r1 = r1; v.f1 = f1;
        return v;
    endfunction

    int rises;

    initial begin
        rst   = 1'b0;
        sw_in = 16'h0000;
        model_clear();

        // Hold 0x0003, then drop bit0; sw_in applied before each listed edge.
        tbl[0]  = mk(16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[1]  = mk(16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[2]  = mk(16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0003, 16'h0000);
        tbl[3]  = mk(16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0000);
        tbl[4]  = mk(16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0000);
        tbl[5]  = mk(16'h0003, 16'h0003, 16'h0003, 16'h0000, 16'h0003, 16'h0000, 16'h0000);
        tbl[6]  = mk(16'h0003, 16'h0003, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0000);
        tbl[7]  = mk(16'h0002, 16'h0003, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0000);
        tbl[8]  = mk(16'h0002, 16'h0003, 16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0000);
        tbl[9]  = mk(16'h0002, 16'h0003, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0001);
        tbl[10] = mk(16'h0002, 16'h0003, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0000);
        tbl[11] = mk(16'h0002, 16'h0003, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0000);
        tbl[12] = mk(16'h0002, 16'h0002, 16'h0000, 16'h0001, 16'h0002, 16'h0000, 16'h0000);
        tbl[13] = mk(16'h0002, 16'h0002, 16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0000);

        #1 rst = 1'b1;
        #1;
        chk("init out4", out4, 16'h0000);
        chk("init out1", out1, 16'h0000);
        chk("init rise4", rise4, 16'h0000);
        chk("init fall4", fall4, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            sw_in = tbl[i].sw;
            step();
            chk($sformatf("tbl%0d out4", i),  out4,  tbl[i].o4);
            chk($sformatf("tbl%0d rise4", i), rise4, tbl[i].r4);
            chk($sformatf("tbl%0d fall4", i), fall4, tbl[i].f4);
            chk($sformatf("tbl%0d out1", i),  out1,  tbl[i].o1);
            chk($sformatf("tbl%0d rise1", i), rise1, tbl[i].r1);
            chk($sformatf("tbl%0d fall1", i), fall1, tbl[i].f1);
        end

        // Three-cycle glitch on bit0 must never reach the STABLE_CYCLES=4 output.
        do_reset("glitch");
        sw_in = 16'h0000;
        for (int i = 0; i < 11; i++) begin
            sw_in = (i >= 2 && i < 5) ? 16'h0001 : 16'h0000;
            step();
            chk($sformatf("glitch%0d out4", i),  out4,  16'h0000);
            chk($sformatf("glitch%0d rise4", i), rise4, 16'h0000);
            chk($sformatf("glitch%0d fall4", i), fall4, 16'h0000);
            chk_model($sformatf("glitch%0d", i));
        end

        // Bits 2 and 9 set together while bit5 bounces every cycle.
        do_reset("multi");
        for (int i = 0; i < 9; i++) begin
            sw_in = 16'h0204 | ((i % 2 == 0) ? 16'h0020 : 16'h0000);
            step();
            chk_model($sformatf("multi%0d", i));
            if (i == 5) begin
                chk("multi edge6 out4",  out4,  16'h0204);
                chk("multi edge6 rise4", rise4, 16'h0204);
            end
            chk($sformatf("multi%0d bit5", i), out4 & 16'h0020, 16'h0000);
        end

        // Reset in the middle of a count discards it; full latency afterwards.
        do_reset("midcnt");
        sw_in = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_model($sformatf("midcnt pre%0d", i));
        end
        do_reset("midcnt");
        rises = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_model($sformatf("midcnt post%0d", i));
            if (rise4[0]) rises++;
            if (i < 5) chk($sformatf("midcnt post%0d hold", i), out4, 16'h0000);
            if (i == 5) chk("midcnt accept", out4, 16'h0001);
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL midcnt rise count: got %0d expected 1", rises);
        end

        // Random slowly-varying inputs against the reference model.
        do_reset("rand");
        for (int i = 0; i < 400; i++) begin
            logic [15:0] flip;
            flip = '0;
            for (int b = 0; b < 16; b++)
                if ($urandom_range(0, 5) == 0) flip[b] = 1'b1;
            sw_in = sw_in ^ flip;
            step();
            chk_model($sformatf("rand%0d", i));
            chk($sformatf("rand%0d rise&fall4", i), rise4 & fall4, 16'h0000);
            if (i == 200) do_reset("rand mid");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 16, number of independent switch/button bits conditioned.
REQ-002 Parameter STABLE_CYCLES, default 250000, consecutive clk cycles a new level must persist before it is accepted; legal range 1..2^24.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port sw_in  input  WIDTH  raw asynchronous board switch/button levels.
REQ-006 Port sw_out  output  WIDTH  debounced, synchronous levels; feeds the mux select/data inputs downstream.
REQ-007 Port rise  output  WIDTH  one-cycle pulse per bit when sw_out bit goes 0->1.
REQ-008 Port fall  output  WIDTH  one-cycle pulse per bit when sw_out bit goes 1->0.

Function
REQ-009 Each bit SHALL pass through a two-flop synchronizer (s1, s2) before any other logic uses it.
REQ-010 Each bit SHALL own a counter of width max(1, clog2(STABLE_CYCLES)) and an accepted-level register q driving sw_out.
REQ-011 Per edge: if s2 == q, the counter SHALL load 0.
REQ-012 Per edge: if s2 != q and counter == STABLE_CYCLES-1, q SHALL load s2 and the counter SHALL load 0.
REQ-013 Per edge: if s2 != q and counter < STABLE_CYCLES-1, the counter SHALL increment by 1; it SHALL never wrap.
REQ-014 A level change first sampled into s1 at edge k and held SHALL appear on sw_out after edge k+STABLE_CYCLES+1 (latency STABLE_CYCLES+2 edges counting edge k as 1).
REQ-015 Any excursion of s2 back to q before acceptance SHALL clear the counter; pulses shorter than STABLE_CYCLES cycles SHALL never reach sw_out.
REQ-016 rise/fall SHALL be registered and asserted for exactly the cycle in which sw_out shows the new value; never both set for the same bit.
REQ-017 STABLE_CYCLES=1 SHALL accept a change on the first edge s2 differs from q.
REQ-018 Bits SHALL be fully independent; simultaneous changes on several bits SHALL each follow REQ-011..016 without interaction.

Reset
REQ-019 While rst=1: s1, s2, q, counters, rise, fall SHALL all be 0, immediately and without a clock edge.
REQ-020 Reset asserted mid-count SHALL discard the count; after release, a 1 held on sw_in SHALL be accepted with full REQ-014 latency and produce a rise pulse.
REQ-021 No output SHALL pulse on the first edge after reset release.

Structure
REQ-022 Package sw_debounce_pkg SHALL hold the default WIDTH, default STABLE_CYCLES and a counter-width function.
REQ-023 One sub-module, debounce_bit (synchronizer, counter, q, edge pulses for one bit), SHALL be instantiated WIDTH times by a generate loop.
REQ-024 No other sub-modules; no latches; no combinational path from sw_in to any output.

Verification (WIDTH=16, STABLE_CYCLES=4)
REQ-025 Reset then sw_in=16'h0003 held -> sw_out stays 0 for 5 edges, equals 16'h0003 after edge 6, rise=16'h0003 for exactly that cycle.
REQ-026 sw_in bit0 toggled high for 3 cycles then low -> sw_out, rise, fall remain 0 throughout.
REQ-027 sw_out=16'h0001, sw_in bit0 dropped and held -> sw_out=0 after edge 6, fall=16'h0001 for one cycle.
REQ-028 Bits 2 and 9 set on the same edge, bit 5 bouncing every cycle -> sw_out=16'h0204 after edge 6, bit 5 never changes.
REQ-029 rst pulsed while bit0 count=2 -> all outputs 0 asynchronously; with sw_in bit0 still 1 after release, sw_out bit0=1 after 6 further edges with one rise pulse.
REQ-030 Rerun REQ-025 with STABLE_CYCLES=1 -> sw_out updates after edge 3.
